// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller beside the M stage: holds SR, Cause, EPC and PRId,
// raises the single-cycle flush request, and services MTC0/MFC0/ERET.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID       = 32'h2021_0007,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hw_int,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [4:0]  m_exc_code,
  input  logic        m_eret,
  input  logic        m_mtc0_we,
  input  logic [4:0]  m_cp0_addr,
  input  logic [31:0] m_wdata,
  output logic        req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc,
  output logic [31:0] rdata
);

  logic [5:0]  srIm_q, srIm_d;
  logic        srExl_q, srExl_d;
  logic        srIe_q, srIe_d;
  logic        causeBd_q, causeBd_d;
  logic [5:0]  causeIp_q, causeIp_d;
  logic [4:0]  causeExc_q, causeExc_d;
  logic [31:0] epc_q, epc_d;

  logic intPend;
  logic excPend;

  assign intPend = (|(hw_int & srIm_q)) & srIe_q & ~srExl_q & m_valid;
  assign excPend = (m_exc_code != 5'd0) & ~srExl_q & m_valid;
  assign req     = intPend | excPend;

  assign handler_pc = HANDLER_PC;
  assign epc        = epc_q;

  // A taken request wins over MTC0/ERET because the instruction is replayed after the handler.
  always_comb begin
    srIm_d     = srIm_q;
    srExl_d    = srExl_q;
    srIe_d     = srIe_q;
    causeBd_d  = causeBd_q;
    causeIp_d  = hw_int;
    causeExc_d = causeExc_q;
    epc_d      = epc_q;
    if (req) begin
      srExl_d    = 1'b1;
      causeExc_d = intPend ? 5'd0 : m_exc_code;
      causeBd_d  = m_bd;
      epc_d      = (m_bd ? (m_pc - 32'd4) : m_pc) & 32'hFFFF_FFFC;
    end else begin
      if (m_mtc0_we) begin
        case (m_cp0_addr)
          5'd12: begin
            srIm_d  = m_wdata[15:10];
            srExl_d = m_wdata[1];
            srIe_d  = m_wdata[0];
          end
          5'd14:   epc_d = m_wdata;
          default: ;
        endcase
      end
      // ERET after an SR write in the same cycle still leaves EXL cleared.
      if (m_eret) srExl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      srIm_q     <= 6'd0;
      srExl_q    <= 1'b0;
      srIe_q     <= 1'b0;
      causeBd_q  <= 1'b0;
      causeIp_q  <= 6'd0;
      causeExc_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      srIm_q     <= srIm_d;
      srExl_q    <= srExl_d;
      srIe_q     <= srIe_d;
      causeBd_q  <= causeBd_d;
      causeIp_q  <= causeIp_d;
      causeExc_q <= causeExc_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    case (m_cp0_addr)
      5'd12:   rdata = {16'h0000, srIm_q, 8'h00, srExl_q, srIe_q};
      5'd13:   rdata = {causeBd_q, 15'h0000, causeIp_q, 3'b000, causeExc_q, 2'b00};
      5'd14:   rdata = epc_q;
      5'd15:   rdata = PRID;
      default: rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: a directed vector table with hand-derived expectations,
// then random traffic compared against a word-level model of SR/Cause/EPC.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] PRID_C    = 32'h2021_0007;
  localparam logic [31:0] HANDLER_C = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hw_int;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exc_code;
  logic        m_eret;
  logic        m_mtc0_we;
  logic [4:0]  m_cp0_addr;
  logic [31:0] m_wdata;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc;
  logic [31:0] rdata;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic        eret;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [5:0]  hw;
    logic        expReq;
    logic [31:0] expRdata;
  } vec_t;

  vec_t tbl[$];

  cp0_exc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .hw_int     (hw_int),
    .m_valid    (m_valid),
    .m_pc       (m_pc),
    .m_bd       (m_bd),
    .m_exc_code (m_exc_code),
    .m_eret     (m_eret),
    .m_mtc0_we  (m_mtc0_we),
    .m_cp0_addr (m_cp0_addr),
    .m_wdata    (m_wdata),
    .req        (req),
    .handler_pc (handler_pc),
    .epc        (epc),
    .rdata      (rdata)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic valid, input logic [31:0] pc, input logic bd,
                              input logic [4:0] exc, input logic eret, input logic we,
                              input logic [4:0] addr, input logic [31:0] wdata,
                              input logic [5:0] hw, input logic expReq,
                              input logic [31:0] expRdata);
    vec_t v;
    v.rst = 1'b0; v.valid = valid; v.pc = pc; v.bd = bd; v.exc = exc; v.eret = eret;
    v.we = we; v.addr = addr; v.wdata = wdata; v.hw = hw;
    v.expReq = expReq; v.expRdata = expRdata;
    return v;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset      = v.rst;
    m_valid    = v.valid;
    m_pc       = v.pc;
    m_bd       = v.bd;
    m_exc_code = v.exc;
    m_eret     = v.eret;
    m_mtc0_we  = v.we;
    m_cp0_addr = v.addr;
    m_wdata    = v.wdata;
    hw_int     = v.hw;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic runVec(input vec_t v, input string tag);
    applyStimulus(v);
    checkOutput({tag, ".req"}, {31'd0, req}, {31'd0, v.expReq});
    checkOutput({tag, ".rdata"}, rdata, v.expRdata);
  endtask

  // Word-level reference state.
  logic [31:0] mSr, mCause, mEpc;

  task automatic randomPhase(input int cycles);
    vec_t v;
    logic intP, excP, expReq;
    logic [31:0] expRd;
    mSr = 0; mCause = 0; mEpc = 0;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.rst = 1'b1;
    applyStimulus(v);
    for (int i = 0; i < cycles; i++) begin
      v.rst   = ($urandom % 64) == 0;
      v.valid = ($urandom % 4) != 0;
      v.pc    = $urandom;
      v.bd    = $urandom % 2;
      v.exc   = (($urandom % 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      v.eret  = ($urandom % 6) == 0;
      v.we    = ($urandom % 3) == 0;
      v.addr  = 5'($urandom_range(10, 16));
      v.wdata = (($urandom % 2) == 0) ? ($urandom & 32'h0000_FC01) : $urandom;
      v.hw    = (($urandom % 3) == 0) ? 6'($urandom) : 6'd0;
      applyStimulus(v);

      intP   = ((v.hw & mSr[15:10]) != 6'd0) && mSr[0] && !mSr[1] && v.valid;
      excP   = (v.exc != 5'd0) && !mSr[1] && v.valid;
      expReq = intP || excP;
      case (v.addr)
        5'd12:   expRd = mSr;
        5'd13:   expRd = mCause;
        5'd14:   expRd = mEpc;
        5'd15:   expRd = PRID_C;
        default: expRd = 32'd0;
      endcase
      checkOutput($sformatf("rnd%0d.req", i), {31'd0, req}, {31'd0, expReq});
      checkOutput($sformatf("rnd%0d.rdata", i), rdata, expRd);
      checkOutput($sformatf("rnd%0d.epc", i), epc, mEpc);
      checkOutput($sformatf("rnd%0d.handler_pc", i), handler_pc, HANDLER_C);

      if (v.rst) begin
        mSr = 0; mCause = 0; mEpc = 0;
      end else begin
        mCause = (mCause & ~32'h0000_FC00) | (32'(v.hw) << 10);
        if (expReq) begin
          mSr    = mSr | 32'h2;
          mCause = (mCause & 32'h0000_FC00) | (32'(v.bd) << 31) | (32'(intP ? 5'd0 : v.exc) << 2);
          mEpc   = (v.bd ? v.pc - 32'd4 : v.pc) & 32'hFFFF_FFFC;
        end else begin
          if (v.we && v.addr == 5'd12) mSr = v.wdata & 32'h0000_FC03;
          if (v.we && v.addr == 5'd14) mEpc = v.wdata;
          if (v.eret) mSr = mSr & ~32'h2;
        end
      end
    end
  endtask

  initial begin
    vec_t r;
    r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    r.rst = 1'b1;
    applyStimulus(r);
    applyStimulus(r);

    //           valid pc            bd exc eret we addr   wdata          hw     req rdata
    tbl.push_back(mk(0, 32'h0,       0, 0,  0,  0, 5'd12, 32'h0,         6'd0,  0, 32'h0));
    tbl.push_back(mk(0, 32'h0,       0, 0,  0,  0, 5'd13, 32'h0,         6'd0,  0, 32'h0));
    tbl.push_back(mk(0, 32'h0,       0, 0,  0,  0, 5'd14, 32'h0,         6'd0,  0, 32'h0));
    tbl.push_back(mk(0, 32'h0,       0, 0,  0,  0, 5'd15, 32'h0,         6'd0,  0, PRID_C));
    tbl.push_back(mk(1, 32'h3000,    0, 0,  0,  1, 5'd12, 32'h0000_FC01, 6'd0,  0, 32'h0));
    tbl.push_back(mk(1, 32'h3010,    0, 0,  0,  0, 5'd12, 32'h0,         6'd1,  1, 32'h0000_FC01));
    tbl.push_back(mk(1, 32'h3014,    0, 0,  0,  0, 5'd12, 32'h0,         6'd0,  0, 32'h0000_FC03));
    tbl.push_back(mk(0, 32'h0,       0, 0,  0,  0, 5'd13, 32'h0,         6'd0,  0, 32'h0));
    tbl.push_back(mk(0, 32'h0,       0, 0,  0,  0, 5'd14, 32'h0,         6'd0,  0, 32'h3010));
    tbl.push_back(mk(1, 32'h4180,    0, 0,  1,  0, 5'd12, 32'h0,         6'd0,  0, 32'h0000_FC03));
    tbl.push_back(mk(1, 32'h3024,    1, 10, 0,  0, 5'd12, 32'h0,         6'd0,  1, 32'h0000_FC01));
    tbl.push_back(mk(0, 32'h0,       0, 0,  0,  0, 5'd14, 32'h0,         6'd0,  0, 32'h3020));
    tbl.push_back(mk(0, 32'h0,       0, 0,  0,  0, 5'd13, 32'h0,         6'd0,  0, 32'h8000_0028));
    tbl.push_back(mk(1, 32'h3100,    0, 5,  0,  0, 5'd14, 32'h0,         6'd0,  0, 32'h3020));
    tbl.push_back(mk(0, 32'h0,       0, 0,  0,  0, 5'd14, 32'h0,         6'd0,  0, 32'h3020));
    tbl.push_back(mk(1, 32'h4180,    0, 0,  1,  0, 5'd12, 32'h0,         6'd1,  0, 32'h0000_FC03));
    tbl.push_back(mk(1, 32'h3200,    0, 0,  0,  0, 5'd13, 32'h0,         6'd1,  1, 32'h8000_0428));
    tbl.push_back(mk(0, 32'h0,       0, 0,  0,  0, 5'd14, 32'h0,         6'd0,  0, 32'h3200));
    tbl.push_back(mk(1, 32'h4180,    0, 0,  1,  0, 5'd12, 32'h0,         6'd0,  0, 32'h0000_FC03));
    tbl.push_back(mk(1, 32'h3300,    0, 4,  0,  1, 5'd14, 32'hDEAD_BEEC, 6'd1,  1, 32'h3200));
    tbl.push_back(mk(0, 32'h0,       0, 0,  0,  0, 5'd13, 32'h0,         6'd0,  0, 32'h0000_0400));
    tbl.push_back(mk(0, 32'h0,       0, 0,  0,  0, 5'd14, 32'h0,         6'd0,  0, 32'h3300));
    tbl.push_back(mk(1, 32'h4180,    0, 0,  1,  1, 5'd12, 32'hFFFF_FC03, 6'd0,  0, 32'h0000_FC03));
    tbl.push_back(mk(0, 32'h0,       0, 0,  0,  0, 5'd12, 32'h0,         6'd0,  0, 32'h0000_FC01));
    tbl.push_back(mk(1, 32'h3400,    0, 0,  0,  1, 5'd13, 32'hFFFF_FFFF, 6'd0,  0, 32'h0));
    tbl.push_back(mk(0, 32'h0,       0, 0,  0,  0, 5'd13, 32'h0,         6'd0,  0, 32'h0));

    for (int i = 0; i < tbl.size(); i++) runVec(tbl[i], $sformatf("tbl%0d", i));

    // Bubbles hold off a level interrupt until a real instruction reaches M.
    for (int i = 0; i < 3; i++)
      runVec(mk(0, 32'h5000, 0, 0, 0, 0, 5'd14, 32'h0, 6'd1, 0, 32'h3300), $sformatf("bubble%0d", i));
    runVec(mk(1, 32'h3500, 0, 0, 0, 0, 5'd14, 32'h0, 6'd1, 1, 32'h3300), "bubbleTake");
    runVec(mk(0, 32'h0, 0, 0, 0, 0, 5'd14, 32'h0, 6'd0, 0, 32'h3500), "bubbleEpc");
    checkOutput("epcPort", epc, 32'h3500);
    runVec(mk(0, 32'h0, 0, 0, 0, 0, 5'd12, 32'h0, 6'd0, 0, 32'h0000_FC03), "inHandler");

    // Reset inside the handler leaves interrupts masked.
    r = mk(1, 32'h0, 0, 0, 0, 0, 5'd12, 32'h0, 6'd1, 0, 32'h0);
    r.rst = 1'b1;
    applyStimulus(r);
    runVec(mk(1, 32'h3600, 0, 0, 0, 0, 5'd12, 32'h0, 6'd1, 0, 32'h0), "postReset");
    runVec(mk(1, 32'h3604, 0, 0, 0, 0, 5'd13, 32'h0, 6'd0, 0, 32'h0000_0400), "postResetIp");
    checkOutput("handler_pc", handler_pc, HANDLER_C);

    randomPhase(500);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline. It sits beside the M stage and holds SR, Cause, EPC and PRId. It decides whether the instruction currently in M is interrupted or faults, and drives the single-cycle Req that flushes every pipeline register and redirects fetch to the handler. It also executes MTC0/MFC0 accesses and ERET.

Parameters:
PRID, 32'h2021_0007, read-only value returned for CP0 register 15
HANDLER_PC, 32'h0000_4180, exception entry address driven on handler_pc

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
hw_int  input  6  external interrupt lines (timer0, timer1, irq), level-sensitive
m_valid  input  1  M stage holds a real instruction (0 for a bubble or flushed slot)
m_pc  input  32  PC of the M-stage instruction
m_bd  input  1  M-stage instruction is in a branch delay slot
m_exc_code  input  5  exception code accumulated through F/D/E/M; 0 = none
m_eret  input  1  M-stage instruction is ERET
m_mtc0_we  input  1  M-stage MTC0 write enable
m_cp0_addr  input  5  CP0 register index for MTC0/MFC0
m_wdata  input  32  MTC0 write data
req  output  1  exception/interrupt taken this cycle; flushes all stage registers
handler_pc  output  32  constant HANDLER_PC
epc  output  32  current EPC, consumed by ERET redirect
rdata  output  32  MFC0 read data for m_cp0_addr

Behaviour:
- Register fields:
  - SR(12): IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
  - Cause(13): BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0.
  - EPC(14): 32 bits.
  - PRId(15) = PRID.
- Reset (synchronous): SR=0, Cause=0, EPC=0. req=0 and rdata reflects the zeroed registers in the cycle after reset.
- IP tracking: Cause.IP <= hw_int every cycle, including during req. Held at 0 only while reset is asserted.
- Pending terms (combinational):
  - int_pend = |(hw_int & SR.IM) & SR.IE & ~SR.EXL & m_valid
  - exc_pend = (m_exc_code != 0) & ~SR.EXL & m_valid
- req = int_pend | exc_pend. It is combinational, with zero latency in the same cycle as the M-stage instruction, and is high for exactly the cycles the condition holds. After the taken edge EXL=1, so req drops the next cycle.
- On a clock edge with req=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= 0 if int_pend (interrupt has priority over exceptions), else m_exc_code.
  - Cause.BD <= m_bd.
  - EPC <= (m_bd ? m_pc - 4 : m_pc) with bits [1:0] forced to 0.
- ERET: on an edge with m_eret=1 and req=0, SR.EXL <= 0. epc is already driven for the redirect.
- MTC0: on an edge with m_mtc0_we=1 and req=0, write the addressed register.
  - addr 12 writes IM, EXL, IE only.
  - addr 13 is ignored.
  - addr 14 writes full EPC.
  - Any other address is ignored.
- Simultaneous events:
  - req beats MTC0 and ERET; the write or ERET is dropped, since the instruction is re-executed after the handler.
  - MTC0 to SR in the same cycle as ERET: MTC0 value is applied first, then EXL is cleared.
- MFC0: rdata = selected register, combinational from current state (pre-edge). Unimplemented indices return 0.
- Bubbles: m_valid=0 suppresses req even with hw_int asserted. The interrupt is taken on the next valid M instruction.
- Nested events: while EXL=1, neither interrupts nor exceptions raise req; state is frozen except IP, MTC0 and ERET.
- Reset mid-handler: clears EXL, so interrupts stay masked until software sets IE/IM.

Test Plan:
- Reset, then MFC0 of 12/13/14/15 → rdata = 0, 0, 0, 32'h2021_0007; req=0.
- MTC0 SR=32'h0000_FC01; hw_int=6'b000001 with m_valid=1, m_pc=32'h0000_3010 → req=1 same cycle; next cycle SR=32'h0000_FC03, ExcCode=0, EPC=32'h0000_3010, req=0.
- m_exc_code=5'd10, m_bd=1, m_pc=32'h0000_3024, EXL=0 → req=1; EPC=32'h0000_3020, Cause.BD=1, ExcCode=10.
- Interrupt and exception together (IE=1, IM[10]=1, hw_int[0]=1, m_exc_code=4) → ExcCode=0. Same-cycle MTC0 EPC=32'hDEAD_BEEC is dropped.
- Exception with EXL=1 → req=0 and EPC unchanged. Then ERET → EXL=0; a pending hw_int now raises req on the next valid instruction.
- hw_int high with m_valid=0 for 3 cycles → req=0. m_valid=1 on cycle 4 → req=1 with EPC = that m_pc.
